// File: rtl/mult_min_issuer.sv
// Issues buffered operand triples to the mult-and-min unit one at a time
// and returns each result (or a watchdog timeout) in push order.
module mult_min_issuer #(
  parameter int unsigned n       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             in_a,
  input  logic [n-1:0]             in_b,
  input  logic [n-1:0]             in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [n-1:0]             out_result,
  output logic                     out_overflow,
  output logic                     out_timeout,
  output logic                     unit_start,
  output logic [n-1:0]             unit_inA,
  output logic [n-1:0]             unit_inB,
  output logic [n-1:0]             unit_inC,
  input  logic                     unit_ready,
  input  logic                     unit_overflow,
  input  logic [n-1:0]             unit_result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = 3 * n;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] head;
  logic          push;
  logic          pop;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [TW-1:0] timer_q;
  logic          timeout_hit;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign pending     = count_q;
  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // Operands come straight from the FIFO head, which only moves on pop.
  assign head     = mem[rd_ptr_q];
  assign unit_inA = head[DW-1:2*n];
  assign unit_inB = head[2*n-1:n];
  assign unit_inC = head[n-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_a, in_b, in_c};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ARM exists so a stale ready level from the previous op is never sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT:  if (unit_ready || timeout_hit) state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state; ready beats timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      unit_start   <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_timeout  <= 1'b0;
      timer_q      <= '0;
    end else begin
      unit_start <= (state_d == S_ISSUE);
      busy       <= (state_d != S_IDLE);
      out_valid  <= (state_d == S_RESP);
      if (state_q == S_ARM) begin
        timer_q <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + TW'(1);
      end
      if (state_q == S_WAIT) begin
        if (unit_ready) begin
          out_result   <= unit_result;
          out_overflow <= unit_overflow;
          out_timeout  <= 1'b0;
        end else if (timeout_hit) begin
          out_result   <= '0;
          out_overflow <= 1'b0;
          out_timeout  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_min_issuer.sv
// Bench for mult_min_issuer: queue-based reference model, behavioural unit
// model with latency L, per-cycle compare process and directed scenarios.
module tb_mult_min_issuer;

  localparam int unsigned N       = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int          L       = 5;
  localparam int          MODE_NORMAL = 0;
  localparam int          MODE_STALE  = 1;
  localparam int          MODE_NEVER  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_result;
  logic         out_overflow, out_timeout;
  logic         unit_start;
  logic [N-1:0] unit_inA, unit_inB, unit_inC;
  logic         unit_ready = 1'b0;
  logic         unit_overflow = 1'b0;
  logic [N-1:0] unit_result = '0;
  logic         busy;
  logic [$clog2(DEPTH):0] pending;

  mult_min_issuer #(.n(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_timeout(out_timeout),
    .unit_start(unit_start), .unit_inA(unit_inA), .unit_inB(unit_inB), .unit_inC(unit_inC),
    .unit_ready(unit_ready), .unit_overflow(unit_overflow), .unit_result(unit_result),
    .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int c; } op_t;
  typedef struct { int result; int ov; int to; int lat; } resp_t;

  int    n_checks = 0;
  int    n_fail = 0;
  int    mode = MODE_NORMAL;
  int    starts_seen = 0;
  op_t   ref_q[$];
  resp_t exp_q[$];
  resp_t got_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Spec-level expectation for one op given how the unit behaves for it.
  function automatic resp_t expect_resp(input op_t o, input int m);
    resp_t r;
    int p;
    p = o.a * o.b;
    if (m == MODE_NEVER) begin
      r.result = 0; r.ov = 0; r.to = 1; r.lat = int'(TIMEOUT) + 2;
    end else begin
      r.result = (p < o.c) ? p : o.c;
      r.ov     = (p > 255) ? 1 : 0;
      r.to     = 0;
      r.lat    = (m == MODE_STALE) ? L + 3 : L + 2;
    end
    return r;
  endfunction

  // Behavioural unit: ready drops on start (one cycle late in stale mode).
  int           u_cnt = 0;
  logic         u_drop = 1'b0;
  logic [N-1:0] u_res = '0;
  logic         u_ov = 1'b0;
  always @(posedge clk) begin
    if (unit_start) begin
      u_res <= ((unit_inA * unit_inB) < {8'd0, unit_inC}) ? N'(unit_inA * unit_inB) : unit_inC;
      u_ov  <= (32'(unit_inA) * 32'(unit_inB)) > 32'd255;
      if (mode == MODE_STALE) begin
        u_drop <= 1'b1;
      end else begin
        unit_ready <= 1'b0;
        u_cnt      <= (mode == MODE_NEVER) ? 0 : L;
      end
    end else if (u_drop) begin
      u_drop     <= 1'b0;
      unit_ready <= 1'b0;
      u_cnt      <= L;
    end else if (u_cnt == 1) begin
      unit_ready    <= 1'b1;
      unit_result   <= u_res;
      unit_overflow <= u_ov;
      u_cnt         <= 0;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
    end
  end

  // Reference model: FIFO contents and outstanding expected response.
  logic ref_full;
  resp_t new_r;
  always @(posedge clk) begin
    if (reset) begin
      ref_q.delete();
      exp_q.delete();
    end else begin
      ref_full = (ref_q.size() >= DEPTH);
      if (unit_start && ref_q.size() > 0) begin
        new_r = expect_resp(ref_q[0], mode);
        exp_q.push_back(new_r);
      end
      if (out_valid && out_ready) begin
        got_q.push_back('{int'(out_result), int'(out_overflow), int'(out_timeout), 0});
        if (exp_q.size() > 0) exp_q.delete(0);
        if (ref_q.size() > 0) ref_q.delete(0);
      end
      if (in_valid && !ref_full) ref_q.push_back('{int'(in_a), int'(in_b), int'(in_c)});
    end
  end

  // Per-cycle comparison against the reference model.
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;
  logic lat_on = 1'b0;
  int   lat_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0;
      prev_valid = 1'b0;
      lat_on = 1'b0;
    end else begin
      check("pending", 32'(pending), 32'(ref_q.size()));
      check("in_ready", 32'(in_ready), 32'(ref_q.size() < DEPTH));
      if (unit_start) begin
        starts_seen++;
        check("one_outstanding", 32'(exp_q.size()), 32'd0);
        check("start_single_cycle", 32'(prev_start), 32'd0);
        lat_on = 1'b1;
        lat_cnt = 0;
      end else if (lat_on) begin
        lat_cnt++;
      end
      if (busy && ref_q.size() > 0) begin
        check("unit_inA", 32'(unit_inA), 32'(ref_q[0].a));
        check("unit_inB", 32'(unit_inB), 32'(ref_q[0].b));
        check("unit_inC", 32'(unit_inC), 32'(ref_q[0].c));
      end
      if (out_valid) begin
        check("busy_in_resp", 32'(busy), 32'd1);
        check("resp_expected", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          check("out_result", 32'(out_result), 32'(exp_q[0].result));
          check("out_overflow", 32'(out_overflow), 32'(exp_q[0].ov));
          check("out_timeout", 32'(out_timeout), 32'(exp_q[0].to));
          if (!prev_valid) check("resp_latency", 32'(lat_cnt), 32'(exp_q[0].lat));
        end
        lat_on = 1'b0;
      end
      prev_start = unit_start;
      prev_valid = out_valid;
    end
  end

  task automatic push(input int a, input int b, input int c);
    int   tries;
    logic acc;
    tries = 0;
    in_valid = 1'b1;
    in_a = N'(a); in_b = N'(b); in_c = N'(c);
    do begin
      acc = in_ready;
      @(negedge clk);
      tries++;
    end while (!acc && tries < 200);
    check("push_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int k);
    int t;
    t = 0;
    while (got_q.size() < k && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("resp_count", 32'(got_q.size()), 32'(k));
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic check_got(input int idx, input int res, input int ov, input int to);
    if (got_q.size() > idx) begin
      check("got_result", 32'(got_q[idx].result), 32'(res));
      check("got_overflow", 32'(got_q[idx].ov), 32'(ov));
      check("got_timeout", 32'(got_q[idx].to), 32'(to));
    end else begin
      check("got_present", 32'(got_q.size()), 32'(idx + 1));
    end
  endtask

  int s0;
  initial begin
    // 1: reset with in_valid asserted
    reset = 1'b1; in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_c = 8'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_overflow", 32'(out_overflow), 32'd0);
    check("rst_out_timeout", 32'(out_timeout), 32'd0);
    check("rst_unit_start", 32'(unit_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; in_valid = 1'b0;

    // 2: single op
    got_q.delete();
    s0 = starts_seen;
    push(3, 4, 20);
    wait_valid();
    check("t2_inA_in_resp", 32'(unit_inA), 32'd3);
    check("t2_result", 32'(out_result), 32'd12);
    wait_got(1);
    check_got(0, 12, 0, 0);
    check("t2_start_count", 32'(starts_seen - s0), 32'd1);

    // 3: back-to-back until full
    got_q.delete();
    push(5, 3, 15);
    push(2, 2, 9);
    push(16, 16, 7);
    push(1, 1, 1);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    check("t3_full_pending", 32'(pending), 32'd4);
    push(9, 9, 9);
    wait_got(5);
    check_got(0, 15, 0, 0);
    check_got(1, 4, 0, 0);
    check_got(2, 7, 1, 0);
    check_got(3, 1, 0, 0);
    check_got(4, 9, 0, 0);

    // 4: back-pressure, push while full, push during pop
    got_q.delete();
    out_ready = 1'b0;
    push(10, 2, 50);
    push(3, 3, 100);
    push(20, 20, 255);
    push(0, 5, 3);
    wait_valid();
    s0 = starts_seen;
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_result", 32'(out_result), 32'd20);
      check("t4_hold_overflow", 32'(out_overflow), 32'd0);
      check("t4_hold_pending", 32'(pending), 32'd4);
    end
    check("t4_no_restart", 32'(starts_seen - s0), 32'd0);
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2; in_c = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_full_ignored", 32'(pending), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_after_pop", 32'(pending), 32'd3);
    wait_valid();
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_c = 8'd7; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_push_pop_same", 32'(pending), 32'd3);
    wait_got(5);
    check_got(0, 20, 0, 0);
    check_got(1, 9, 0, 0);
    check_got(2, 255, 1, 0);
    check_got(3, 0, 0, 0);
    check_got(4, 7, 0, 0);

    // 5: stale ready, then no ready at all, then a normal op
    got_q.delete();
    check("t5_stale_level", 32'(unit_ready), 32'd1);
    mode = MODE_STALE;
    push(4, 5, 100);
    wait_got(1);
    check_got(0, 20, 0, 0);
    mode = MODE_NEVER;
    push(6, 6, 50);
    wait_got(2);
    check_got(1, 0, 0, 1);
    mode = MODE_NORMAL;
    push(7, 3, 30);
    wait_got(3);
    check_got(2, 21, 0, 0);

    // 6: reset during WAIT with three entries buffered
    got_q.delete();
    push(8, 8, 100);
    push(1, 2, 3);
    push(4, 4, 4);
    @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    check("t6_pending_before", 32'(pending), 32'd3);
    check("t6_no_resp_yet", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_pending", 32'(pending), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    push(2, 3, 10);
    wait_got(1);
    check_got(0, 6, 0, 0);
    repeat (30) @(negedge clk);
    check("t6_no_stray_resp", 32'(got_q.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_min_issuer.md
Name: mult_min_issuer

Overview:
Initiator for the mult-and-min unit's start/ready handshake. It buffers operand triples in a small FIFO and issues them to the unit one at a time. For each triple it pulses start, holds the operands stable, waits for ready or a watchdog timeout, then returns result, overflow and timeout flags on a valid/ready output port in issue order.

Parameters:
n, 8, operand/result width; must match the unit's n
DEPTH, 4, operand FIFO entries; power of 2, >=2
TIMEOUT, 255, max cycles spent in WAIT before the op is abandoned; >=1

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operand triple offered
in_ready  output  1  FIFO not full
in_a, in_b, in_c  input  n each  operands
out_valid  output  1  response available
out_ready  input  1  consumer accepts response
out_result  output  n  captured unit result (0 on timeout)
out_overflow  output  1  captured unit overflow (0 on timeout)
out_timeout  output  1  op abandoned by watchdog
unit_start  output  1  start pulse to unit
unit_inA, unit_inB, unit_inC  output  n each  operands to unit = FIFO head
unit_ready  input  1  unit done
unit_overflow  input  1  unit overflow
unit_result  input  n  unit result
busy  output  1  FSM not in IDLE
pending  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sync, any state): FSM=IDLE, FIFO flushed. Resulting values: pending=0, in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_timeout=0, unit_start=0, busy=0, timer=0. The unit is not reset by this block; the next start reinitialises it.
- FIFO: push on in_valid&in_ready; pop only on the RESP handshake.
  - Push and pop in the same cycle is allowed; pending stays unchanged.
  - When full, in_ready=0 and in_valid is ignored.
  - Pointers wrap modulo DEPTH.
- unit_inA/B/C are driven combinationally from the FIFO head. They are stable from ISSUE through RESP because the head changes only at pop.
- FSM states:
  - IDLE: if pending>0, go to ISSUE next cycle.
  - ISSUE: unit_start=1 for exactly this one cycle; go to ARM.
  - ARM: unit_ready is ignored, since it may still hold the previous op's stale level; clear timer; go to WAIT.
  - WAIT: timer increments each cycle.
    - If unit_ready=1: capture out_result<=unit_result, out_overflow<=unit_overflow, out_timeout<=0; go to RESP.
    - Else if timer==TIMEOUT-1: out_result<=0, out_overflow<=0, out_timeout<=1; go to RESP.
    - If unit_ready and timeout coincide, ready wins.
  - RESP: out_valid=1, outputs held stable until out_ready. On out_valid&out_ready: pop FIFO, go to IDLE.
- Latency:
  - unit_start rises 1 cycle after the first cycle the FIFO is non-empty in IDLE.
  - out_valid rises 1 cycle after the WAIT cycle that sees unit_ready.
  - One IDLE bubble between consecutive ops.
- Results are returned in push order; at most one op is outstanding at the unit.
- busy=1 in ISSUE, ARM, WAIT and RESP.
- Reset mid-operation (any state) discards the in-flight op and all buffered ops. No response is produced for them.

Test Plan:
(Bench: n=8, DEPTH=4, TIMEOUT=15; behavioural unit model with latency L=5 that computes a*b min c, overflow when a*b>255; the model's ready drops on start.)
1. Assert reset for 2 cycles with in_valid=1 -> all outputs at reset values, pending=0, no push accepted.
2. Push (3,4,20) -> unit_start high for exactly 1 cycle; unit_inA/B/C = 3/4/20 held through RESP; out_valid with out_result=12, out_overflow=0, out_timeout=0.
3. Push (5,3,15), (2,2,9), (16,16,7), (1,1,1), (9,9,9) back-to-back with out_ready=1 -> 5th push sees in_ready=0 until first pop; responses in order: 15 / 4 / overflow=1 / 1. Push (9,9,9) again after in_ready rises; it completes in order.
4. out_ready=0 for 10 cycles during RESP -> out_result/out_overflow stable, out_valid held, no second unit_start, pending unchanged. Simultaneous push while full is ignored; push during the pop cycle keeps pending unchanged.
5. Model that holds unit_ready=1 through ISSUE and ARM, then drops it and reasserts after L -> response comes from the new op, not the stale level. Model that never asserts ready -> out_valid after 15 WAIT cycles with out_timeout=1 and out_result=0; the next op proceeds normally.
6. Reset asserted during WAIT with 3 entries pending -> next cycle pending=0, out_valid=0, busy=0. A subsequent push (2,3,10) yields out_result=6.
